// File: rtl/bcd_keypad_ctrl_pkg.sv
// Shared types and helpers for the decimal keypad controller.
package bcd_kp_pkg;

  localparam int BCD_W = 4;
  localparam int KEY_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  function automatic logic onehot_chk(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/bcd_keypad_ctrl_if.sv
// Digit handshake between the keypad controller and its consumer.
interface bcd_keypad_ctrl_if;
  import bcd_kp_pkg::*;

  logic             digit_valid;
  logic             digit_ready;
  logic [BCD_W-1:0] digit_bcd;

  modport master (output digit_valid, output digit_bcd, input digit_ready);
  modport slave  (input digit_valid, input digit_bcd, output digit_ready);

endinterface

// File: rtl/bcd_encoder.sv
// One-hot decimal key vector to BCD; zero when no bit is set.
module bcd_encoder
  import bcd_kp_pkg::*;
(
  input  logic [KEY_W-1:0] i_onehot,
  output logic [BCD_W-1:0] o_bcd
);

  always_comb begin
    o_bcd = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (i_onehot[i]) o_bcd = BCD_W'(i);
    end
  end

endmodule

// File: rtl/bcd_keypad_ctrl.sv
// Keypad sequencer: sync, debounce, single-key qualify, digit handshake and
// a shifting BCD number register.
//
// state       | meaning
// ST_IDLE     | waiting for any key
// ST_DEBOUNCE | counting identical samples of the candidate pattern
// ST_EMIT     | digit offered on the handshake until accepted
// ST_RELEASE  | waiting for keys to stay up for DEB_CYCLES samples
module bcd_keypad_ctrl
  import bcd_kp_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [KEY_W-1:0]             i_key_in,
  input  logic                         i_clear,
  bcd_keypad_ctrl_if.master            dig_if,
  output logic [BCD_W*DIGITS-1:0]      o_number_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  o_digit_count,
  output logic                         o_full,
  output logic                         o_err_multi
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam int DC_W  = $clog2(DIGITS + 1);
  localparam int NUM_W = BCD_W * DIGITS;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [DC_W-1:0]  DC_MAX  = DC_W'(DIGITS);

  logic [KEY_W-1:0] r_sync1, r_key_s;
  logic [KEY_W-1:0] r_cand, w_cand_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  state_t           r_state, w_state_nxt;
  logic [NUM_W-1:0] r_num;
  logic [DC_W-1:0]  r_count;
  logic [BCD_W-1:0] w_enc;
  logic             w_valid, w_accept;

  bcd_encoder u_enc (
    .i_onehot (r_cand),
    .o_bcd    (w_enc)
  );

  assign w_valid            = (r_state == ST_EMIT);
  assign w_accept           = w_valid && dig_if.digit_ready;
  assign dig_if.digit_valid = w_valid;
  assign dig_if.digit_bcd   = w_valid ? w_enc : '0;
  assign o_number_bcd       = r_num;
  assign o_digit_count      = r_count;
  assign o_full             = (r_count == DC_MAX);
  assign o_err_multi        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_key_s <= '0;
      r_state <= ST_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= i_key_in;
      r_key_s <= r_sync1;
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_key_s != '0) begin
          w_cand_nxt  = r_key_s;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (r_key_s != r_cand) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == DEB_MAX) begin
          w_cnt_nxt = '0;
          if (onehot_chk(r_cand)) begin
            w_state_nxt = ST_EMIT;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_EMIT: begin
        // key state is ignored here so a release cannot drop valid
        if (w_accept) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (r_key_s != '0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DEB_MAX - CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // clear has priority; an accepted digit in the same cycle is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_num   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_num <= (r_num << BCD_W) | NUM_W'(w_enc);
      if (r_count != DC_MAX) r_count <= r_count + DC_W'(1);
    end
  end

endmodule
